// File: rtl/fp_align_prep.sv
// fp_align_prep: two-stage operand preparation for an FP32 adder.
// S1 unpacks both operands, subtracts exponents (9-bit) and compares mantissas.
// S2 swaps so the larger magnitude comes first, clamps the shift, registers outputs.
// Optional feature macro: FP_SUBNORMAL_EN (defined -> subnormals unpacked,
// undefined -> exponent-0 operands flushed to zero).
module fp_align_prep #(
    parameter int unsigned SHIFT_CLAMP = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] big_mant,
    output logic [23:0] small_mant,
    output logic [4:0]  shift,
    output logic [7:0]  big_exp,
    output logic        sign_big,
    output logic        eff_sub,
    output logic        swapped
);

    localparam logic [7:0] CLAMP = 8'(SHIFT_CLAMP);

    // S1 pipeline registers
    logic        s1_valid_q, s1_valid_d;
    logic [23:0] s1_mant_a_q, s1_mant_b_q;
    logic [7:0]  s1_exp_a_q, s1_exp_b_q;
    logic        s1_sign_a_q, s1_sign_b_q;
    logic [8:0]  s1_diff_q;
    logic        s1_a_big_q;

    // S2 (output) registers
    logic        out_valid_q, out_valid_d;
    logic [23:0] big_mant_q, small_mant_q;
    logic [4:0]  shift_q;
    logic [7:0]  big_exp_q;
    logic        sign_big_q, eff_sub_q, swapped_q;

    // Unpack results and S1 compare outcome
    logic [23:0] mant_a_d, mant_b_d;
    logic [7:0]  exp_a_d, exp_b_d;
    logic [8:0]  diff_d;
    logic        a_big_d;

    // S2 next values
    logic [23:0] big_mant_d, small_mant_d;
    logic [4:0]  shift_d;
    logic [7:0]  big_exp_d;
    logic        sign_big_d, eff_sub_d, swapped_d;
    logic [8:0]  neg_diff;
    logic [7:0]  mag;

    logic accept, s1_adv;

    // Handshake: S1 drains whenever S2 is empty or being consumed
    always_comb begin
        s1_adv      = s1_valid_q && (!out_valid_q || out_ready);
        in_ready    = !s1_valid_q || !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        s1_valid_d  = accept || (s1_valid_q && !s1_adv);
        out_valid_d = s1_adv || (out_valid_q && !out_ready);
    end

    // Unpack operands, exponent difference and magnitude compare
    always_comb begin
`ifdef FP_SUBNORMAL_EN
        mant_a_d = {(a[30:23] != 8'd0), a[22:0]};
        mant_b_d = {(b[30:23] != 8'd0), b[22:0]};
        exp_a_d  = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        exp_b_d  = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
`else
        mant_a_d = (a[30:23] == 8'd0) ? '0 : {1'b1, a[22:0]};
        mant_b_d = (b[30:23] == 8'd0) ? '0 : {1'b1, b[22:0]};
        exp_a_d  = a[30:23];
        exp_b_d  = b[30:23];
`endif
        diff_d = {1'b0, exp_a_d} - {1'b0, exp_b_d};
        // Exact ties keep A as the larger operand
        if (diff_d[8])
            a_big_d = 1'b0;
        else if (diff_d != 9'd0)
            a_big_d = 1'b1;
        else
            a_big_d = (mant_a_d >= mant_b_d);
    end

    // S1 register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mant_a_q <= '0;
            s1_mant_b_q <= '0;
            s1_exp_a_q  <= '0;
            s1_exp_b_q  <= '0;
            s1_sign_a_q <= 1'b0;
            s1_sign_b_q <= 1'b0;
            s1_diff_q   <= '0;
            s1_a_big_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_mant_a_q <= mant_a_d;
                s1_mant_b_q <= mant_b_d;
                s1_exp_a_q  <= exp_a_d;
                s1_exp_b_q  <= exp_b_d;
                s1_sign_a_q <= a[31];
                s1_sign_b_q <= b[31];
                s1_diff_q   <= diff_d;
                s1_a_big_q  <= a_big_d;
            end
        end
    end

    // Swap into big/small order and saturate the shift amount
    always_comb begin
        neg_diff     = '0 - s1_diff_q;
        mag          = s1_a_big_q ? s1_diff_q[7:0] : neg_diff[7:0];
        shift_d      = (mag > CLAMP) ? CLAMP[4:0] : mag[4:0];
        big_mant_d   = s1_a_big_q ? s1_mant_a_q : s1_mant_b_q;
        small_mant_d = s1_a_big_q ? s1_mant_b_q : s1_mant_a_q;
        big_exp_d    = s1_a_big_q ? s1_exp_a_q  : s1_exp_b_q;
        sign_big_d   = s1_a_big_q ? s1_sign_a_q : s1_sign_b_q;
        eff_sub_d    = s1_sign_a_q ^ s1_sign_b_q;
        swapped_d    = !s1_a_big_q;
    end

    // S2 output registers, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            big_mant_q   <= '0;
            small_mant_q <= '0;
            shift_q      <= '0;
            big_exp_q    <= '0;
            sign_big_q   <= 1'b0;
            eff_sub_q    <= 1'b0;
            swapped_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s1_adv) begin
                big_mant_q   <= big_mant_d;
                small_mant_q <= small_mant_d;
                shift_q      <= shift_d;
                big_exp_q    <= big_exp_d;
                sign_big_q   <= sign_big_d;
                eff_sub_q    <= eff_sub_d;
                swapped_q    <= swapped_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign big_mant   = big_mant_q;
    assign small_mant = small_mant_q;
    assign shift      = shift_q;
    assign big_exp    = big_exp_q;
    assign sign_big   = sign_big_q;
    assign eff_sub    = eff_sub_q;
    assign swapped    = swapped_q;

endmodule

// File: doc/fp_align_prep.md
FP_ALIGN_PREP -- requirements
Module: fp_align_prep

Interface
REQ-001 SHALL have parameter SHIFT_CLAMP, default 31: saturation value of shift output (max 31, ≥24).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  1  operand pair valid.
REQ-005 SHALL have port in_ready  out  1  stage can accept operand pair.
REQ-006 SHALL have port a  in  32  IEEE-754 single operand A.
REQ-007 SHALL have port b  in  32  IEEE-754 single operand B.
REQ-008 SHALL have port out_valid  out  1  aligned-prep result valid.
REQ-009 SHALL have port out_ready  in  1  downstream (alignment right shifter) accepts.
REQ-010 SHALL have port big_mant  out  24  larger-magnitude mantissa incl. hidden bit.
REQ-011 SHALL have port small_mant  out  24  smaller-magnitude mantissa incl. hidden bit; feeds right shifter data input.
REQ-012 SHALL have port shift  out  5  exponent difference, saturated; feeds right shifter shift input.
REQ-013 SHALL have port big_exp  out  8  effective exponent of larger operand.
REQ-014 SHALL have port sign_big  out  1  sign of larger operand.
REQ-015 SHALL have port eff_sub  out  1  sign(a) XOR sign(b).
REQ-016 SHALL have port swapped  out  1  1 when B is the larger-magnitude operand.

Function
REQ-017 SHALL be a 2-stage registered pipeline: S1 unpack + 9-bit exponent subtract + mantissa compare; S2 swap, clamp, output registers.
REQ-018 SHALL present a result on outputs exactly 2 cycles after acceptance (in_valid && in_ready) when out_ready stays high.
REQ-019 SHALL sustain 1 transaction/cycle with out_ready high; in_ready SHALL be combinational: !s1_valid || !out_valid || out_ready.
REQ-020 SHALL hold all outputs stable while out_valid && !out_ready; no transaction dropped, duplicated or reordered.
REQ-021 SHALL advance S1->S2 when S2 is empty or being consumed in the same cycle; simultaneous accept and consume SHALL both complete.
REQ-022 SHALL unpack normal operands (exp 1..254) as mantissa {1,frac}, effective exponent = exp field.
REQ-023 SHALL select larger magnitude by exponent, then mantissa on equal exponent; exact tie SHALL select A (swapped=0).
REQ-024 SHALL compute shift = min(big_exp - small_exp, SHIFT_CLAMP).
REQ-025 SHALL pass exponent 255 (Inf/NaN) through as ordinary field values; special handling belongs downstream.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear s1_valid, out_valid and all data outputs to 0; in_ready SHALL read 1 during and after reset.
REQ-027 SHALL discard in-flight transactions on reset mid-operation; none reappear after release.

Configuration
REQ-028 SHALL use macro FP_SUBNORMAL_EN: defined -> exponent 0 unpacks as {0,frac} with effective exponent 1; undefined -> exponent 0 flushes to mantissa 0, effective exponent 0.

Verification
REQ-029 SHALL test a=0x40400000, b=0x3F800000 -> big_mant 0xC00000, small_mant 0x800000, shift 1, big_exp 128, swapped 0, eff_sub 0, out_valid 2 cycles after accept.
REQ-030 SHALL test a=0x3F800000, b=0xC1000000 -> swapped 1, big_exp 130, shift 3, sign_big 1, eff_sub 1.
REQ-031 SHALL test a=0x7F000000, b=0x3F800000 -> shift 31 (saturated from 127), small_mant 0x800000.
REQ-032 SHALL test 3 back-to-back transactions with out_ready low -> in_ready drops after 2 accepted, outputs held; out_ready high -> all 3 emerge in order, one per cycle.
REQ-033 SHALL test a=0x00800000, b=0x00000001 -> with FP_SUBNORMAL_EN: small_mant 0x000001, shift 0; without: small_mant 0, shift 1.
REQ-034 SHALL test rst_n pulsed low with 2 transactions in flight -> out_valid 0 immediately, no output after release until new accept.
